// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings, FSM states and lane-mask helper for the load/store unit
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ACC0, ST_WAIT0, ST_ACC1, ST_WAIT1, ST_RESP
  } lsu_state_t;

  // Returns {mask0, mask1, span}: lanes touched in the first and second word.
  function automatic logic [8:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] base;
    logic [7:0] full;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      default: base = 8'h0F;
    endcase
    full = base << off;
    return {full[3:0], full[7:4], |full[7:4]};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane shifting, load byte merge and sign/zero extension
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] st_lo,
  output logic [31:0] st_hi,
  input  logic [31:0] rd_lo,
  input  logic [31:0] rd_hi,
  output logic [31:0] ld_data
);

  logic [31:0] wmask;
  logic [63:0] st_shift;
  logic [63:0] ld_shift;
  logic [31:0] raw;

  always_comb begin
    case (size)
      SZ_B:    wmask = 32'h0000_00FF;
      SZ_H:    wmask = 32'h0000_FFFF;
      default: wmask = 32'hFFFF_FFFF;
    endcase
    st_shift = {32'h0, wdata & wmask} << {off, 3'b000};
    st_lo    = st_shift[31:0];
    st_hi    = st_shift[63:32];

    // Concatenating both words lets one shift serve aligned and split loads.
    ld_shift = {rd_hi, rd_lo} >> {off, 3'b000};
    raw      = ld_shift[31:0];
    case (size)
      SZ_B:    ld_data = {{24{sign_ext & raw[7]}}, raw[7:0]};
      SZ_H:    ld_data = {{16{sign_ext & raw[15]}}, raw[15:0]};
      default: ld_data = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store front end for data_memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS        = 65536,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wren,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam logic [32:0] LIMIT = 33'(MEM_WORDS) * 33'd4;

  lsu_state_t  state;
  logic        r_we, r_signed, r_span;
  logic [1:0]  r_size, r_off;
  logic [31:0] r_w1, r_wdata, rd0;

  logic        idle, span, misal, err;
  logic [3:0]  mask0, mask1;
  logic [31:0] w0, w1;
  logic [1:0]  a_size, a_off;
  logic        a_signed;
  logic [31:0] a_wdata, st_lo, st_hi, rd_lo, ld_data;

  assign idle      = (state == ST_IDLE);
  assign req_ready = idle;

  // In IDLE the live request drives the datapath; afterwards the captured copy does.
  assign a_size   = idle ? req_size   : r_size;
  assign a_off    = idle ? req_addr[1:0] : r_off;
  assign a_signed = idle ? req_signed : r_signed;
  assign a_wdata  = idle ? req_wdata  : r_wdata;
  assign {mask0, mask1, span} = lane_mask(a_size, a_off);

  assign w0    = {req_addr[31:2], 2'b00};
  assign w1    = w0 + 32'd4;
  assign misal = ((req_size == SZ_H) && req_addr[0]) ||
                 ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
  assign err   = (req_size == 2'b11) || ({1'b0, w0} >= LIMIT) ||
                 (span && (({1'b0, w1} >= LIMIT) || (w1 == 32'h0))) ||
                 (!ALLOW_MISALIGNED && misal);

  assign rd_lo = (state == ST_WAIT1) ? rd0 : mem_rdata;

  lsu_align u_align (
    .size    (a_size),
    .off     (a_off),
    .sign_ext(a_signed),
    .wdata   (a_wdata),
    .st_lo   (st_lo),
    .st_hi   (st_hi),
    .rd_lo   (rd_lo),
    .rd_hi   (mem_rdata),
    .ld_data (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_wren   <= 4'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      r_we       <= 1'b0;
      r_signed   <= 1'b0;
      r_span     <= 1'b0;
      r_size     <= 2'b00;
      r_off      <= 2'b00;
      r_w1       <= 32'h0;
      r_wdata    <= 32'h0;
      rd0        <= 32'h0;
    end else begin
      mem_wren <= 4'h0;
      case (state)
        ST_IDLE: if (req_valid) begin
          r_we     <= req_we;
          r_signed <= req_signed;
          r_span   <= span;
          r_size   <= req_size;
          r_off    <= req_addr[1:0];
          r_w1     <= w1;
          r_wdata  <= req_wdata;
          if (err) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'h0;
          end else begin
            state    <= ST_ACC0;
            mem_addr <= w0;
            if (req_we) begin
              mem_wdata <= st_lo;
              mem_wren  <= mask0;
            end
          end
        end
        ST_ACC0: begin
          if (!r_we) begin
            state <= ST_WAIT0;
          end else if (r_span) begin
            state     <= ST_ACC1;
            mem_addr  <= r_w1;
            mem_wdata <= st_hi;
            mem_wren  <= mask1;
          end else begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
          end
        end
        ST_WAIT0: begin
          rd0 <= mem_rdata;
          if (r_span) begin
            state    <= ST_ACC1;
            mem_addr <= r_w1;
          end else begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= ld_data;
          end
        end
        ST_ACC1: begin
          if (r_we) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
          end else begin
            state <= ST_WAIT1;
          end
        end
        ST_WAIT1: begin
          state      <= ST_RESP;
          resp_valid <= 1'b1;
          resp_rdata <= ld_data;
        end
        ST_RESP: if (resp_ready) begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
          resp_rdata <= 32'h0;
          resp_err   <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and randomized bench for load_store_unit
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam longint LIMIT = 65536 * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0, resp_ready = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] mem_addr, mem_wdata, resp_rdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [3:0]  mem_wren;

  logic        b_req_valid = 1'b0, b_req_we = 1'b0, b_resp_ready = 1'b0;
  logic [1:0]  b_req_size = 2'b00;
  logic [31:0] b_req_addr = 32'h0;
  logic        b_req_ready, b_resp_valid, b_resp_err;
  logic [31:0] b_mem_addr, b_mem_wdata, b_resp_rdata;
  logic [3:0]  b_mem_wren;

  bit [31:0] mem  [0:65535];
  bit [7:0]  refm [0:262143];

  int checks = 0;
  int failures = 0;

  logic [31:0] wa_q[$];
  logic [3:0]  we_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] got_rdata;
  logic        got_err;
  int          got_lat;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(65536), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  load_store_unit #(.MEM_WORDS(65536), .ALLOW_MISALIGNED(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_size(b_req_size), .req_signed(1'b0),
    .req_addr(b_req_addr), .req_wdata(32'h0), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_wren(b_mem_wren), .mem_rdata(32'h0),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata),
    .resp_err(b_resp_err)
  );

  // Synchronous-read data_memory stand-in.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_wren[i]) mem[mem_addr[17:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    mem_rdata <= mem[mem_addr[17:2]];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] w);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[8*k +: 8] = refm[int'(w[17:0]) + k];
    return v;
  endfunction

  task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] ad, input logic [31:0] wd, input int dly);
    int          n;
    logic [31:0] w0, w1, exp_rd;
    bit          span, e;
    int          exp_lat;
    n    = (sz == 2'b11) ? 4 : (1 << sz);
    w0   = {ad[31:2], 2'b00};
    w1   = w0 + 32'd4;
    span = (int'(ad[1:0]) + n) > 4;
    e    = (sz == 2'b11) || (longint'(w0) >= LIMIT) ||
           (span && ((longint'(w1) >= LIMIT) || (w1 == 32'h0)));
    exp_lat = e ? 1 : (we ? (span ? 3 : 2) : (span ? 5 : 3));
    exp_rd  = 32'h0;
    if (!e && we) begin
      for (int k = 0; k < n; k++) refm[int'(ad[17:0]) + k] = wd[8*k +: 8];
    end else if (!e) begin
      for (int k = 0; k < n; k++) exp_rd[8*k +: 8] = refm[int'(ad[17:0]) + k];
      if (sg && sz == SZ_B && exp_rd[7])  exp_rd[31:8]  = 24'hFFFFFF;
      if (sg && sz == SZ_H && exp_rd[15]) exp_rd[31:16] = 16'hFFFF;
    end
    wa_q.delete(); we_q.delete(); wd_q.delete();

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = ad; req_wdata = wd;
    check("req_ready_idle", req_ready, 1'b1);
    @(posedge clk);
    got_lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (!resp_valid && got_lat < 20) begin
      if (mem_wren != 4'h0) begin
        wa_q.push_back(mem_addr); we_q.push_back(mem_wren); wd_q.push_back(mem_wdata);
      end
      @(posedge clk);
      got_lat++;
      @(negedge clk);
    end
    got_rdata = resp_rdata;
    got_err   = resp_err;
    check("latency", got_lat, exp_lat);
    check("resp_err", got_err, e);
    check("resp_rdata", got_rdata, exp_rd);
    check("write_cycles", wa_q.size(), (!e && we) ? (span ? 2 : 1) : 0);
    for (int i = 0; i < dly; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", resp_valid, 1'b1);
      check("hold_rdata", resp_rdata, exp_rd);
      check("hold_ready_low", req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_drop", resp_valid, 1'b0);
    check("back_idle", req_ready, 1'b1);
    if (!e && we) begin
      check("mem_w0", mem[w0[17:2]], ref_word(w0));
      if (span) check("mem_w1", mem[w1[17:2]], ref_word(w1));
    end
  endtask

  initial begin
    #1;
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_wren", mem_wren, 4'h0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", resp_err, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_req_ready", req_ready, 1'b1);

    xact(1'b1, SZ_W, 1'b0, 32'h3FFF0, 32'd125, 0);
    check("t1_addr", (wa_q.size() > 0) ? wa_q[0] : 32'hX, 32'h3FFF0);
    check("t1_wren", (we_q.size() > 0) ? we_q[0] : 4'hX, 4'hF);
    xact(1'b0, SZ_W, 1'b0, 32'h3FFF0, 32'h0, 0);
    check("t1_load", got_rdata, 32'd125);

    xact(1'b1, SZ_B, 1'b0, 32'h3FFE9, 32'h000000AB, 0);
    check("t2_wren", (we_q.size() > 0) ? we_q[0] : 4'hX, 4'b0010);
    check("t2_lane", (wd_q.size() > 0) ? {24'h0, wd_q[0][15:8]} : 32'hX, 32'hAB);
    xact(1'b0, SZ_B, 1'b1, 32'h3FFE9, 32'h0, 0);
    check("t2_signed", got_rdata, 32'hFFFFFFAB);
    xact(1'b0, SZ_B, 1'b0, 32'h3FFE9, 32'h0, 0);
    check("t2_unsigned", got_rdata, 32'h000000AB);

    xact(1'b1, SZ_W, 1'b0, 32'h103, 32'h11223344, 0);
    check("t3_addr0", (wa_q.size() > 1) ? wa_q[0] : 32'hX, 32'h100);
    check("t3_wren0", (we_q.size() > 1) ? we_q[0] : 4'hX, 4'b1000);
    check("t3_data0", (wd_q.size() > 1) ? {24'h0, wd_q[0][31:24]} : 32'hX, 32'h44);
    check("t3_addr1", (wa_q.size() > 1) ? wa_q[1] : 32'hX, 32'h104);
    check("t3_wren1", (we_q.size() > 1) ? we_q[1] : 4'hX, 4'b0111);
    check("t3_data1", (wd_q.size() > 1) ? {8'h0, wd_q[1][23:0]} : 32'hX, 32'h112233);
    xact(1'b0, SZ_W, 1'b0, 32'h103, 32'h0, 0);
    check("t3_load", got_rdata, 32'h11223344);
    check("t3_lat", got_lat, 5);

    xact(1'b0, SZ_W, 1'b0, 32'h3FFFE, 32'h0, 0);
    check("t4_range_err", got_err, 1'b1);
    xact(1'b1, 2'b11, 1'b0, 32'h200, 32'hDEADBEEF, 0);
    check("t4_size_err", got_err, 1'b1);

    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_size = SZ_H; b_req_addr = 32'h1;
    @(posedge clk);
    @(negedge clk);
    b_req_valid = 1'b0;
    check("b_mis_valid", b_resp_valid, 1'b1);
    check("b_mis_err", b_resp_err, 1'b1);
    check("b_mis_wren", b_mem_wren, 4'h0);
    b_resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_resp_ready = 1'b0;
    check("b_idle", b_req_ready, 1'b1);
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_size = SZ_W; b_req_addr = 32'h40;
    @(posedge clk);
    @(negedge clk);
    b_req_valid = 1'b0;
    check("b_al_lat1", b_resp_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("b_al_lat2", b_resp_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("b_al_valid", b_resp_valid, 1'b1);
    check("b_al_err", b_resp_err, 1'b0);
    b_resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_resp_ready = 1'b0;

    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_W; req_signed = 1'b0; req_addr = 32'h102;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_wren", mem_wren, 4'h0);
    check("t5_valid", resp_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_ready", req_ready, 1'b1);
    @(negedge clk);
    check("t5_no_resp", resp_valid, 1'b0);
    xact(1'b0, SZ_W, 1'b0, 32'h3FFF0, 32'h0, 0);
    check("t5_load", got_rdata, 32'd125);

    xact(1'b0, SZ_W, 1'b0, 32'h103, 32'h0, 3);

    for (int t = 0; t < 60; t++) begin
      logic [31:0] ad;
      logic [1:0]  sz;
      ad = ($urandom_range(0, 7) == 0) ? (32'h3FFF8 + $urandom_range(0, 7))
                                       : (32'h200 + $urandom_range(0, 63));
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      xact(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom,
           $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
